sha256_compress: RTL and testbench

SHA256_COMPRESS -- requirements
Module: sha256_compress

---
 rtl/sha256_compress.sv | 143 ++++++++++++++
 tb/tb_sha256_compress.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_compress.sv
// SHA-256 compression function: one round per clock, 16-word sliding message schedule.
// The usigma helper computes the three-rotation big-sigma functions.

module usigma #(
  parameter int unsigned R0 = 2,
  parameter int unsigned R1 = 13,
  parameter int unsigned R2 = 22
) (
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  assign y_o = ror(x_i, R0) ^ ror(x_i, R1) ^ ror(x_i, R2);

endmodule

module sha256_compress (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] hash_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] hash_out
);

  typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

  localparam logic [31:0] k_table [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  state_e             state_q, state_d;
  logic [5:0]         t_q, t_d;
  // Word-packed like hash_in: index 7 is a / H0, index 0 is h / H7.
  logic [7:0][31:0]   wv_q, wv_d, hin_q, hin_d, hash_q, hash_d;
  // w_q[0] always holds W_t; w_q[15] is the newest word.
  logic [15:0][31:0]  w_q, w_d;
  logic               done_q, done_d;

  logic [31:0] sum0, sum1, ch, maj, t1, t2, w_new;

  usigma #(.R0(2), .R1(13), .R2(22)) u_sum0 (.x_i(wv_q[7]), .y_o(sum0));
  usigma #(.R0(6), .R1(11), .R2(25)) u_sum1 (.x_i(wv_q[3]), .y_o(sum1));

  assign ch    = (wv_q[3] & wv_q[2]) ^ (~wv_q[3] & wv_q[1]);
  assign maj   = (wv_q[7] & wv_q[6]) ^ (wv_q[7] & wv_q[5]) ^ (wv_q[6] & wv_q[5]);
  assign t1    = wv_q[0] + sum1 + ch + k_table[t_q] + w_q[0];
  assign t2    = sum0 + maj;
  assign w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    wv_d    = wv_q;
    hin_d   = hin_q;
    w_d     = w_q;
    hash_d  = hash_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          hin_d = hash_in;
          wv_d  = hash_in;
          t_d   = 6'd0;
          for (int i = 0; i < 16; i++) begin
            w_d[i] = block_in[511 - 32 * i -: 32];
          end
          state_d = StRound;
        end
      end
      StRound: begin
        wv_d = {t1 + t2, wv_q[7], wv_q[6], wv_q[5], wv_q[4] + t1, wv_q[3], wv_q[2], wv_q[1]};
        w_d  = {w_new, w_q[15:1]};
        if (t_q == 6'd63) begin
          state_d = StFinal;
        end else begin
          t_d = t_q + 6'd1;
        end
      end
      StFinal: begin
        for (int i = 0; i < 8; i++) begin
          hash_d[i] = hin_q[i] + wv_q[i];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      t_q     <= '0;
      wv_q    <= '0;
      hin_q   <= '0;
      w_q     <= '0;
      hash_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      wv_q    <= wv_d;
      hin_q   <= hin_d;
      w_q     <= w_d;
      hash_q  <= hash_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign hash_out = hash_q;

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress: known-answer vectors plus random blocks
// checked against a straightforward array-based SHA-256 compression model.

module tb_sha256_compress;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [511:0] block_in;
  logic [255:0] hash_in;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIGEST =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] TWO_BLK1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
    32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLK2 = {480'h0, 32'h000001c0};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_compress dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .block_in (block_in),
    .hash_in  (hash_in),
    .busy     (busy),
    .done     (done),
    .hash_out (hash_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] hv, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  s [8];
    logic [31:0]  x1, x2, sg0, sg1;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32 * i -: 32];
    for (int i = 16; i < 64; i++) begin
      sg0  = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      sg1  = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = sg1 + w[i-7] + sg0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) s[i] = hv[255 - 32 * i -: 32];
    for (int r = 0; r < 64; r++) begin
      x1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
           + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[r] + w[r];
      x2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
           + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + x1;
      s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32 * i -: 32] = hv[255 - 32 * i -: 32] + s[i];
    return res;
  endfunction

  // Starts one block and counts edges until done; lat = 200 means done never came.
  task automatic run_block(input logic [511:0] blk, input logic [255:0] hv, output int lat);
    block_in = blk;
    hash_in  = hv;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; block_in = ABC_BLOCK; hash_in = IV;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if (hash_out !== 256'h0) begin
      errors++; $display("FAIL reset_hash: got %h want 0", hash_out);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, done, hash_out} !== 258'h0) begin
        errors++;
        $display("FAIL idle_quiet cycle %0d: busy=%b done=%b hash=%h want all 0",
                 i, busy, done, hash_out);
      end
    end
  endtask

  task automatic test_abc;
    int lat;
    run_block(ABC_BLOCK, IV, lat);
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL abc_latency: got %0d want 65", lat); end
    checks++;
    if (hash_out !== ABC_DIGEST) begin
      errors++; $display("FAIL abc_digest: got %h want %h", hash_out, ABC_DIGEST);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abc_busy_at_done: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2;
    run_block(TWO_BLK1, IV, lat1);
    checks++;
    if (lat1 !== 65) begin errors++; $display("FAIL b2b_lat1: got %0d want 65", lat1); end
    // Second start is driven while done is still high.
    run_block(TWO_BLK2, hash_out, lat2);
    checks++;
    if (lat2 !== 65) begin errors++; $display("FAIL b2b_lat2: got %0d want 65", lat2); end
    checks++;
    if (hash_out !== TWO_DIGEST) begin
      errors++; $display("FAIL b2b_digest: got %h want %h", hash_out, TWO_DIGEST);
    end
  endtask

  task automatic test_ignored_start;
    int lat, extra;
    block_in = ABC_BLOCK; hash_in = IV; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b want 1", busy); end
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == 10) begin
        start    = 1'b1;
        block_in = {16{$urandom()}};
        hash_in  = {8{$urandom()}};
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL ign_latency: got %0d want 65", lat); end
    checks++;
    if (hash_out !== ABC_DIGEST) begin
      errors++; $display("FAIL ign_digest: got %h want %h", hash_out, ABC_DIGEST);
    end
    extra = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL ign_extra_done: got %0d want 0", extra); end
  endtask

  task automatic test_midrun_reset;
    int lat, extra;
    block_in = ABC_BLOCK; hash_in = IV; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_flags: got busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (hash_out !== 256'h0) begin
      errors++; $display("FAIL rst_mid_hash: got %h want 0", hash_out);
    end
    extra = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL rst_mid_activity: got %0d want 0", extra); end
    run_block(ABC_BLOCK, IV, lat);
    checks++;
    if (lat !== 65 || hash_out !== ABC_DIGEST) begin
      errors++;
      $display("FAIL rst_mid_rerun: got lat=%0d hash=%h want 65 %h", lat, hash_out, ABC_DIGEST);
    end
  endtask

  task automatic test_holdoff;
    int lat;
    block_in = ABC_BLOCK; hash_in = IV; start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    block_in = '1;
    hash_in  = '1;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 65 || hash_out !== ABC_DIGEST) begin
      errors++;
      $display("FAIL holdoff: got lat=%0d hash=%h want 65 %h", lat, hash_out, ABC_DIGEST);
    end
  endtask

  task automatic test_random;
    logic [511:0] blk;
    logic [255:0] hv, exp;
    int lat;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 16; i++) blk = {blk[479:0], 32'($urandom())};
      for (int i = 0; i < 8; i++) hv = {hv[223:0], 32'($urandom())};
      exp = ref_compress(hv, blk);
      run_block(blk, hv, lat);
      checks++;
      if (lat !== 65 || hash_out !== exp) begin
        errors++;
        $display("FAIL random_%0d: got lat=%0d hash=%h want 65 %h", n, lat, hash_out, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; block_in = '0; hash_in = '0;
    test_reset();
    test_idle();
    test_abc();
    test_back_to_back();
    test_ignored_start();
    test_midrun_reset();
    test_holdoff();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
